fp_regfile_sb: RTL and testbench

Parametrised floating-point register file with two asynchronous read ports, two synchronous write ports (FPU result and FP load) and an integrated busy scoreboard. Sits in the decode/writeback path of the FP pipeline. Decode reads operands and busy flags and marks destination registers pending at issue. The FPU and load unit write results back, which clears the pending flags. It is the next generation of the single-write-port FP register file: data width, depth and register-0 handling are parametrised, and it adds hazard tracking and optional write-to-read bypass.

---
 rtl/fp_regfile_sb.sv | 125 ++++++++++++
 tb/tb_fp_regfile_sb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_regfile_sb.sv
// Floating-point register file: two async read ports, FPU and load write ports, busy scoreboard.
// Define FREG_BYPASS_EN to forward same-cycle write data (and busy state) onto the read ports.
module fp_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rbusy_a,
    output logic              rbusy_b,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic [ADDR_W:0]   pend_cnt
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   pend_next;
    logic              wr_ok0;
    logic              wr_ok1;
    logic              iss_ok;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    // Register 0 is hardwired to zero only when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok0 = we0 && !is_zero_reg(waddr0);
    assign wr_ok1 = we1 && !is_zero_reg(waddr1);
    assign iss_ok = issue_en && !is_zero_reg(issue_rd);

    // Port 1 is written first so a colliding port 0 write overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok1) begin
                mem[waddr1] <= wdata1;
            end
            if (wr_ok0) begin
                mem[waddr0] <= wdata0;
            end
        end
    end

    // Writebacks clear first; a same-cycle issue re-sets since the new producer supersedes the old.
    always_comb begin
        busy_next = busy;
        if (wr_ok0) begin
            busy_next[waddr0] = 1'b0;
        end
        if (wr_ok1) begin
            busy_next[waddr1] = 1'b0;
        end
        if (iss_ok) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        pend_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_next = pend_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_next;
            pend_cnt <= pend_next;
        end
    end

    assign rd_addr[0] = raddr_a;
    assign rd_addr[1] = raddr_b;

    for (genvar p = 0; p < 2; p++) begin : g_read
        always_comb begin
            rd_data[p] = mem[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
`ifdef FREG_BYPASS_EN
            if (wr_ok0 && (waddr0 == rd_addr[p])) begin
                rd_data[p] = wdata0;
                rd_busy[p] = iss_ok && (issue_rd == rd_addr[p]);
            end else if (wr_ok1 && (waddr1 == rd_addr[p])) begin
                rd_data[p] = wdata1;
                rd_busy[p] = iss_ok && (issue_rd == rd_addr[p]);
            end
`endif
            // Forced quiet during reset so forwarding cannot leak pending writes.
            if (!rst_n || is_zero_reg(rd_addr[p])) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign rdata_a = rd_data[0];
    assign rdata_b = rd_data[1];
    assign rbusy_a = rd_busy[0];
    assign rbusy_b = rd_busy[1];

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Scoreboard bench for fp_regfile_sb: stimulus queues expected read/pend values, a negedge monitor checks them.
module tb_fp_regfile_sb;

`ifdef FREG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  raddr_a, raddr_b;
    logic [31:0] rdata_a, rdata_b;
    logic        rbusy_a, rbusy_b;
    logic        we0, we1, issue_en;
    logic [4:0]  waddr0, waddr1, issue_rd;
    logic [31:0] wdata0, wdata1;
    logic [5:0]  pend_cnt;

    typedef enum int {SIG_DATA_A, SIG_BUSY_A, SIG_DATA_B, SIG_BUSY_B, SIG_PEND} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   n_compared;
    int   n_mismatched;

    fp_regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .rbusy_a  (rbusy_a),
        .rbusy_b  (rbusy_b),
        .we0      (we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                                  input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                                  input logic ie, input logic [4:0] ird,
                                  input logic [4:0] ra, input logic [4:0] rb);
        we0 = e0; waddr0 = a0; wdata0 = d0;
        we1 = e1; waddr1 = a1; wdata1 = d1;
        issue_en = ie; issue_rd = ird;
        raddr_a = ra; raddr_b = rb;
    endtask

    task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, ra, rb);
    endtask

    task automatic expect_val(input sig_e s, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc = cyc; e.sig = s; e.exp = v; e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        logic [31:0] act;
        case (e.sig)
            SIG_DATA_A: act = rdata_a;
            SIG_BUSY_A: act = {31'b0, rbusy_a};
            SIG_DATA_B: act = rdata_b;
            SIG_BUSY_B: act = {31'b0, rbusy_b};
            default:    act = {26'b0, pend_cnt};
        endcase
        n_compared++;
        if (act !== e.exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", e.name, act, e.exp, e.cyc);
        end
    endtask

    // Monitor: at each falling edge, retire every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL stale_%s: got no sample, expected one at cycle %0d", e.name, e.cyc);
            end else begin
                check_output(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int addrs [5];
        n_compared   = 0;
        n_mismatched = 0;
        addrs = '{0, 1, 5, 17, 31};
        rst_n = 1'b0;
        idle_read(5'd0, 5'd0);
        tick(); tick();

        // Reset held: attempted writes/issues must not show on any output.
        foreach (addrs[i]) begin
            apply_stimulus(1'b1, 5'(addrs[i]), 32'hDEADBEEF, 1'b1, 5'd2, 32'hCAFEF00D,
                           1'b1, 5'(addrs[i]), 5'(addrs[i]), 5'(31 - addrs[i]));
            expect_val(SIG_DATA_A, 32'h0, "rst_data_a");
            expect_val(SIG_BUSY_A, 32'h0, "rst_busy_a");
            expect_val(SIG_DATA_B, 32'h0, "rst_data_b");
            expect_val(SIG_PEND,   32'h0, "rst_pend");
            tick();
        end
        idle_read(5'd5, 5'd0);
        rst_n = 1'b1;
        tick();

        // r5 write, visible next cycle.
        apply_stimulus(1'b1, 5'd5, 32'h3F800000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        expect_val(SIG_DATA_A, BYP ? 32'h3F800000 : 32'h0, "r5_same_cycle");
        tick();
        idle_read(5'd5, 5'd0);
        expect_val(SIG_DATA_A, 32'h3F800000, "r5_readback");
        expect_val(SIG_BUSY_A, 32'h0, "r5_not_busy");
        tick();

        // Dual write to distinct registers.
        apply_stimulus(1'b1, 5'd3, 32'h40000000, 1'b1, 5'd7, 32'h40400000, 1'b0, 5'd0, 5'd3, 5'd7);
        expect_val(SIG_DATA_A, BYP ? 32'h40000000 : 32'h0, "r3_same_cycle");
        expect_val(SIG_DATA_B, BYP ? 32'h40400000 : 32'h0, "r7_same_cycle");
        tick();
        idle_read(5'd3, 5'd7);
        expect_val(SIG_DATA_A, 32'h40000000, "r3_readback");
        expect_val(SIG_DATA_B, 32'h40400000, "r7_readback");
        tick();

        // Collision on r9: port 0 wins.
        apply_stimulus(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_val(SIG_DATA_A, BYP ? 32'hA : 32'h0, "r9_same_cycle");
        tick();
        idle_read(5'd9, 5'd3);
        expect_val(SIG_DATA_A, 32'hA, "r9_collision");
        expect_val(SIG_DATA_B, 32'h40000000, "r3_untouched");
        tick();

        // Issue r4.
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd5);
        expect_val(SIG_BUSY_A, 32'h0, "r4_busy_pre_edge");
        expect_val(SIG_PEND,   32'h0, "pend_pre_issue");
        tick();
        idle_read(5'd4, 5'd5);
        expect_val(SIG_BUSY_A, 32'h1, "r4_busy");
        expect_val(SIG_BUSY_B, 32'h0, "r5_idle");
        expect_val(SIG_PEND,   32'h1, "pend_after_issue");
        tick();

        // Load writeback clears r4.
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h40800000, 1'b0, 5'd0, 5'd4, 5'd0);
        expect_val(SIG_DATA_A, BYP ? 32'h40800000 : 32'h0, "r4_wb_same_data");
        expect_val(SIG_BUSY_A, BYP ? 32'h0 : 32'h1, "r4_wb_same_busy");
        tick();
        idle_read(5'd4, 5'd0);
        expect_val(SIG_DATA_A, 32'h40800000, "r4_data");
        expect_val(SIG_BUSY_A, 32'h0, "r4_cleared");
        expect_val(SIG_PEND,   32'h0, "pend_after_wb");
        tick();

        // Issue and write r6 together: busy set wins, data still written.
        apply_stimulus(1'b1, 5'd6, 32'hC0000000, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd6, 5'd0);
        expect_val(SIG_DATA_A, BYP ? 32'hC0000000 : 32'h0, "r6_same_data");
        expect_val(SIG_BUSY_A, 32'h0 | BYP, "r6_same_busy");
        tick();
        idle_read(5'd6, 5'd0);
        expect_val(SIG_DATA_A, 32'hC0000000, "r6_data");
        expect_val(SIG_BUSY_A, 32'h1, "r6_busy");
        expect_val(SIG_PEND,   32'h1, "pend_r6");
        tick();

        // Re-issue of already busy r6.
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd6, 5'd0);
        tick();
        idle_read(5'd6, 5'd0);
        expect_val(SIG_BUSY_A, 32'h1, "r6_reissue_busy");
        expect_val(SIG_PEND,   32'h1, "pend_reissue");
        tick();

        // Register 0 ignores writes, issues and bypass.
        apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        expect_val(SIG_DATA_A, 32'h0, "r0_same_data");
        expect_val(SIG_BUSY_A, 32'h0, "r0_same_busy");
        tick();
        idle_read(5'd0, 5'd0);
        expect_val(SIG_DATA_A, 32'h0, "r0_data");
        expect_val(SIG_BUSY_B, 32'h0, "r0_busy");
        expect_val(SIG_PEND,   32'h1, "pend_r0");
        tick();

        // Bypass observation on port b.
        apply_stimulus(1'b1, 5'd2, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd2);
        expect_val(SIG_DATA_B, BYP ? 32'h12345678 : 32'h0, "r2_same_cycle");
        tick();
        idle_read(5'd0, 5'd2);
        expect_val(SIG_DATA_B, 32'h12345678, "r2_next_cycle");
        tick();

        // Build up five busy registers: r6 plus r10..r13.
        for (int r = 10; r < 14; r++) begin
            apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'd10, 5'd13);
            tick();
        end
        idle_read(5'd10, 5'd13);
        expect_val(SIG_BUSY_A, 32'h1, "r10_busy");
        expect_val(SIG_BUSY_B, 32'h1, "r13_busy");
        expect_val(SIG_PEND,   32'h5, "pend_five");
        tick();

        // Asynchronous reset pulse between edges.
        idle_read(5'd6, 5'd3);
        #1;
        rst_n = 1'b0;
        expect_val(SIG_DATA_A, 32'h0, "async_rst_r6_data");
        expect_val(SIG_BUSY_A, 32'h0, "async_rst_r6_busy");
        expect_val(SIG_DATA_B, 32'h0, "async_rst_r3_data");
        expect_val(SIG_PEND,   32'h0, "async_rst_pend");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b1, 5'd5, 32'h11111111, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd5, 5'd8);
        tick();
        idle_read(5'd5, 5'd8);
        expect_val(SIG_DATA_A, 32'h11111111, "post_rst_write");
        expect_val(SIG_BUSY_B, 32'h1, "post_rst_issue");
        expect_val(SIG_DATA_B, 32'h0, "post_rst_r8_data");
        expect_val(SIG_PEND,   32'h1, "post_rst_pend");
        tick();
        idle_read(5'd6, 5'd2);
        expect_val(SIG_BUSY_A, 32'h0, "post_rst_r6_clear");
        expect_val(SIG_DATA_B, 32'h0, "post_rst_r2_data");
        tick();
        tick();
        tick();

        if (sb_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL leftover: got %0d unchecked entries, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
